bpr_frame_ctrl: RTL and testbench
=================================

BPR_FRAME_CTRL -- requirements
Module: bpr_frame_ctrl

Interface
REQ-001 SHALL have parameter IMG_RES_X, default 336, active pixels per line.
REQ-002 SHALL have parameter IMG_RES_Y, default 256, active lines per frame.
REQ-003 SHALL have parameter DP_RST_CYCLES, default 4, datapath reset pulse length in cycles, legal range 1-255.
REQ-004 SHALL have one clock and one synchronous, active-high reset; polarity and synchronicity are fixed.
REQ-005 Ports SHALL be:
- axis_aclk  in  1  clock.
- axis_areset  in  1  synchronous active-high reset.
- enable  in  1  run request, level.
- s_axis_tdata  in  16  sensor pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of line.
- s_axis_tuser  in  1  start of frame (SOF).
- m_axis_tdata  out  16  pixel to border generator.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  regenerated end of line.
- dp_rst  out  1  datapath reset to border generator and replacer, active high.
- busy  out  1  high in any state except ST_IDLE.
- frame_done  out  1  one-cycle pulse per completed frame.
- err_pulse  out  1  one-cycle pulse per framing error.
- frame_cnt  out  16  completed-frame counter.

Function
REQ-006 The FSM SHALL have the states ST_IDLE, ST_DP_RST, ST_WAIT_SOF, ST_PASS and ST_DONE, held in a 3-bit state register.
REQ-007 In ST_IDLE, s_axis_tready=0 and m_axis_tvalid=0; the FSM SHALL go to ST_DP_RST when enable=1.
REQ-008 In ST_DP_RST, dp_rst=1 for exactly DP_RST_CYCLES cycles, then ST_WAIT_SOF; s_axis_tready=0 and m_axis_tvalid=0 throughout.
REQ-009 In ST_WAIT_SOF, s_axis_tready=~s_axis_tuser and m_axis_tvalid=0; beats without SOF are discarded.
REQ-010 In ST_WAIT_SOF, s_axis_tvalid=1 with s_axis_tuser=1 SHALL move the FSM to ST_PASS without consuming that beat.
REQ-011 In ST_PASS the path SHALL be combinational with 0 latency:
- m_axis_tdata=s_axis_tdata
- m_axis_tvalid=s_axis_tvalid
- s_axis_tready=m_axis_tready
REQ-012 In ST_PASS, x_cnt/y_cnt (16 bit) SHALL advance only on s_axis_tvalid&m_axis_tready; x wraps at IMG_RES_X-1 to 0 and increments y.
REQ-013 m_axis_tlast SHALL be 1 only in ST_PASS with x_cnt==IMG_RES_X-1, independent of s_axis_tlast.
REQ-014 A short line (accepted beat, s_axis_tlast=1, x_cnt<IMG_RES_X-1) SHALL give err_pulse=1 next cycle and go to ST_DP_RST.
REQ-015 A long line (accepted beat, x_cnt==IMG_RES_X-1, s_axis_tlast=0) SHALL give err_pulse=1 next cycle and go to ST_DP_RST.
REQ-016 A mid-frame SOF (accepted beat, s_axis_tuser=1, (x_cnt,y_cnt)!=(0,0)) SHALL give err_pulse=1 next cycle and go to ST_DP_RST.
REQ-017 When one beat has several errors, the FSM SHALL give a single err_pulse.
REQ-018 The accepted beat at x_cnt=IMG_RES_X-1, y_cnt=IMG_RES_Y-1 with no error SHALL move the FSM to ST_DONE.
REQ-019 In ST_DONE, frame_done=1 for one cycle and frame_cnt increments, wrapping 0xFFFF->0; the FSM then goes to ST_WAIT_SOF if enable=1, else ST_IDLE.
REQ-020 enable=0 during ST_PASS SHALL let the current frame complete; enable=0 in ST_WAIT_SOF SHALL move the FSM to ST_IDLE next cycle.
REQ-021 Counters SHALL clear on entry to ST_PASS and ST_DP_RST.

Reset
REQ-022 While axis_areset=1, the FSM SHALL be in ST_IDLE with:
- s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
- dp_rst=1
- busy=0, frame_done=0, err_pulse=0
- frame_cnt=0, x_cnt=0, y_cnt=0
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no frame_done and no err_pulse.

Configuration
REQ-024 Macro BPR_FRAME_CTRL_ERR_CNT_EN, when defined, SHALL add output err_cnt[15:0]:
- counts err_pulse events, saturating at 0xFFFF
- cleared by reset and by a rising edge of enable.
REQ-025 Without BPR_FRAME_CTRL_ERR_CNT_EN, port err_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-026 Reset, enable=1, one clean 336x256 frame preceded by 10 junk beats -> junk dropped, 86016 beats forwarded, m_axis_tlast on every 336th, frame_done once, frame_cnt=1.
REQ-027 Clean frame with random m_axis_tready backpressure of about 50% -> output data identical and in order, no beat lost or duplicated.
REQ-028 s_axis_tlast at pixel 100 of line 5 -> err_pulse 1 cycle, dp_rst high 4 cycles, next SOF frame completes normally, err_cnt=1 if macro defined.
REQ-029 SOF at line 10 pixel 0 -> err_pulse, ST_DP_RST, then re-sync on next SOF; frame_cnt unchanged.
REQ-030 enable dropped at line 128 -> frame completes, frame_done, busy=0 two cycles later; reset at line 50 of next run -> all outputs at reset values, no frame_done.

Source files
------------

// File: rtl/bpr_frame_ctrl.sv
// ---------------------------------------------------------------------------
// bpr_frame_ctrl
// Frame controller in front of the bad-pixel-replacement border generator.
// After a run request it pulses the datapath reset, waits for a start of frame,
// then passes one frame straight through (zero latency) while checking the
// line length and SOF position. It regenerates tlast from its own pixel count.
// A framing error pulses err_pulse and resynchronises through the datapath reset.
//
// Handshake: a beat moves on an AXI-Stream port when tvalid and tready are both
// high at the rising clock edge. tvalid never depends on tready. tready may
// depend on tvalid and tuser.
//
// Parameters: IMG_RES_X (pixels/line), IMG_RES_Y (lines/frame),
//             DP_RST_CYCLES (datapath reset pulse length, 1..255)
// Ports:
//   axis_aclk, axis_areset        clock, synchronous active-high reset
//   enable                        run request (level)
//   s_axis_*                      sensor pixel stream in (tdata/tvalid/tready/tlast/tuser=SOF)
//   m_axis_*                      pixel stream out (tdata/tvalid/tready/tlast)
//   dp_rst                        datapath reset, active high
//   busy                          high whenever the FSM is not idle
//   frame_done, err_pulse         one-cycle event pulses
//   frame_cnt                     completed-frame counter (wraps)
//   err_cnt                       saturating error counter, only present when
//                                 BPR_FRAME_CTRL_ERR_CNT_EN is defined
// ---------------------------------------------------------------------------
module bpr_frame_ctrl #(
    parameter int IMG_RES_X     = 336,
    parameter int IMG_RES_Y     = 256,
    parameter int DP_RST_CYCLES = 4
) (
    input  logic        axis_aclk,
    input  logic        axis_areset,
    input  logic        enable,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        dp_rst,
    output logic        busy,
    output logic        frame_done,
    output logic        err_pulse,
    output logic [15:0] frame_cnt
`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam logic [15:0] X_LAST   = 16'(IMG_RES_X - 1);
    localparam logic [15:0] Y_LAST   = 16'(IMG_RES_Y - 1);
    localparam logic [7:0]  RST_LAST = 8'(DP_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DP_RST   = 3'd1,
        ST_WAIT_SOF = 3'd2,
        ST_PASS     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] x_cnt_q, x_cnt_d;
    logic [15:0] y_cnt_q, y_cnt_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic        err_q, err_d;

    logic at_x_last, at_y_last, beat_ok, beat_err;

    always_comb begin
        at_x_last = (x_cnt_q == X_LAST);
        at_y_last = (y_cnt_q == Y_LAST);
        beat_ok   = s_axis_tvalid & m_axis_tready;
        // Short line, long line and mid-frame SOF fold into one error so a
        // beat with several faults still gives a single pulse.
        beat_err  = (s_axis_tlast & ~at_x_last)
                  | (at_x_last & ~s_axis_tlast)
                  | (s_axis_tuser & ((x_cnt_q != 16'd0) || (y_cnt_q != 16'd0)));

        state_d       = state_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        rst_cnt_d     = rst_cnt_q;
        err_d         = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tdata  = 16'd0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        dp_rst        = 1'b0;
        frame_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d   = ST_DP_RST;
                    rst_cnt_d = 8'd0;
                    x_cnt_d   = 16'd0;
                    y_cnt_d   = 16'd0;
                end
            end
            ST_DP_RST: begin
                dp_rst = 1'b1;
                if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_SOF;
                else                       rst_cnt_d = rst_cnt_q + 8'd1;
            end
            ST_WAIT_SOF: begin
                // Junk beats are swallowed; the SOF beat is held for ST_PASS.
                s_axis_tready = ~s_axis_tuser;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (s_axis_tvalid && s_axis_tuser) begin
                    state_d = ST_PASS;
                    x_cnt_d = 16'd0;
                    y_cnt_d = 16'd0;
                end
            end
            ST_PASS: begin
                m_axis_tdata  = s_axis_tdata;
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tlast  = at_x_last;
                if (beat_ok) begin
                    if (beat_err) begin
                        err_d     = 1'b1;
                        state_d   = ST_DP_RST;
                        rst_cnt_d = 8'd0;
                        x_cnt_d   = 16'd0;
                        y_cnt_d   = 16'd0;
                    end else if (at_x_last) begin
                        x_cnt_d = 16'd0;
                        if (at_y_last) state_d = ST_DONE;
                        else           y_cnt_d = y_cnt_q + 16'd1;
                    end else begin
                        x_cnt_d = x_cnt_q + 16'd1;
                    end
                end
            end
            ST_DONE: begin
                frame_done  = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                state_d     = enable ? ST_WAIT_SOF : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy      = (state_q != ST_IDLE);
        err_pulse = err_q;
        frame_cnt = frame_cnt_q;

        // Outputs take their reset values immediately, not one edge later.
        if (axis_areset) begin
            s_axis_tready = 1'b0;
            m_axis_tdata  = 16'd0;
            m_axis_tvalid = 1'b0;
            m_axis_tlast  = 1'b0;
            dp_rst        = 1'b1;
            frame_done    = 1'b0;
            busy          = 1'b0;
            err_pulse     = 1'b0;
            frame_cnt     = 16'd0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q     <= ST_IDLE;
            x_cnt_q     <= 16'd0;
            y_cnt_q     <= 16'd0;
            frame_cnt_q <= 16'd0;
            rst_cnt_q   <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_cnt_q     <= x_cnt_d;
            y_cnt_q     <= y_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            rst_cnt_q   <= rst_cnt_d;
            err_q       <= err_d;
        end
    end

`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
    logic        enable_q;
    logic [15:0] err_cnt_q;

    // A fresh run request (rising enable) starts the error count over.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            enable_q  <= 1'b0;
            err_cnt_q <= 16'd0;
        end else begin
            enable_q <= enable;
            if (enable && !enable_q)
                err_cnt_q <= 16'd0;
            else if (err_q && (err_cnt_q != 16'hFFFF))
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = axis_areset ? 16'd0 : err_cnt_q;
`else
    // No error counter in this build.
`endif

endmodule

// File: tb/tb_bpr_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bpr_frame_ctrl
// Directed bench for bpr_frame_ctrl on a reduced 8x4 frame. The bench knows
// which sensor beats belong to a synchronised frame and where line ends must
// fall; it queues the expected output beats and a per-cycle monitor checks
// every forwarded beat, the datapath reset pulse length and the pulse shapes.
// ---------------------------------------------------------------------------
module tb_bpr_frame_ctrl;

    localparam int X = 8;
    localparam int Y = 4;
    localparam int R = 4;

    localparam int K_CLEAN = 0;
    localparam int K_SHORT = 1;
    localparam int K_SOF   = 2;
    localparam int K_LONG  = 3;
    localparam int K_DROP  = 4;
    localparam int K_RST   = 5;

    logic        clk;
    logic        areset;
    logic        enable;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic        s_tuser;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        dp_rst;
    logic        busy;
    logic        frame_done;
    logic        err_pulse;
    logic [15:0] frame_cnt;
`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    bpr_frame_ctrl #(.IMG_RES_X(X), .IMG_RES_Y(Y), .DP_RST_CYCLES(R)) dut (
        .axis_aclk    (clk),
        .axis_areset  (areset),
        .enable       (enable),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .s_axis_tuser (s_tuser),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .dp_rst       (dp_rst),
        .busy         (busy),
        .frame_done   (frame_done),
        .err_pulse    (err_pulse),
        .frame_cnt    (frame_cnt)
`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];      // {expected tlast, expected tdata}
    int n_chk  = 0;
    int n_fail = 0;
    int done_seen  = 0;
    int err_seen   = 0;
    int fwd_seen   = 0;
    int tlast_seen = 0;
    int dp_runs    = 0;
    int frames_exp = 0;
    int errs_exp   = 0;
    bit bp_en      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- output backpressure ----------------
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- per-cycle monitor ----------------
    initial begin
        int  run;
        bit  err_prev;
        logic [16:0] e;
        run = 0;
        err_prev = 0;
        forever begin
            @(negedge clk);
            if (areset) begin
                run = 0;
                err_prev = 0;
            end else begin
                if (m_tvalid && m_tready) begin
                    fwd_seen++;
                    if (m_tlast) tlast_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_tdata", 32'(m_tdata), 32'(e[15:0]));
                        check("m_tlast", 32'(m_tlast), 32'(e[16]));
                    end
                end
                if (m_tvalid) check("pass_ready", 32'(s_tready), 32'(m_tready));
                if (!busy) begin
                    check("idle_s_tready", 32'(s_tready), 32'd0);
                    check("idle_m_tvalid", 32'(m_tvalid), 32'd0);
                end
                if (dp_rst) begin
                    run++;
                end else if (run != 0) begin
                    check("dp_rst_len", run, R);
                    dp_runs++;
                    run = 0;
                end
                if (err_pulse) begin
                    err_seen++;
                    check("err_one_cycle", 32'(err_prev), 32'd0);
                end
                err_prev = err_pulse;
                if (frame_done) done_seen++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input logic [15:0] d, input logic last, input logic user);
        bit ok;
        ok = 0;
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = user;
        s_tvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_junk(input int n);
        for (int i = 0; i < n; i++) send_beat(16'($urandom_range(0, 65535)), 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int kind, input int eline, input int epix);
        for (int y = 0; y < Y; y++) begin
            for (int x = 0; x < X; x++) begin
                logic        last;
                logic        user;
                logic [15:0] d;
                bit          stop;
                last = (x == X - 1);
                user = (x == 0 && y == 0);
                stop = 0;
                if (kind == K_DROP && y == eline && x == 0) enable = 1'b0;
                if (kind == K_RST && y == eline && x == 0) begin
                    areset = 1'b1;
                    return;
                end
                if (kind == K_SHORT && y == eline && x == epix) begin last = 1'b1; stop = 1; end
                if (kind == K_SOF   && y == eline && x == 0)    begin user = 1'b1; stop = 1; end
                if (kind == K_LONG  && y == eline && x == X-1)  begin last = 1'b0; stop = 1; end
                d = 16'($urandom_range(0, 65535));
                exp_q.push_back({(x == X - 1), d});
                send_beat(d, last, user);
                if (stop) begin
                    @(negedge clk);
                    check("err_pulse_next", 32'(err_pulse), 32'd1);
                    check("dp_rst_after_err", 32'(dp_rst), 32'd1);
                    errs_exp++;
                    @(posedge clk);
                    #1;
                    return;
                end
            end
        end
    endtask

    // Waits (bounded) for frame_done; returns at the negedge where it is seen.
    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("frame_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic clean_frame_and_check();
        send_frame(K_CLEAN, 0, 0);
        wait_done();
        frames_exp++;
        @(negedge clk);
        check("frame_cnt", 32'(frame_cnt), frames_exp);
        check("queue_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        areset   = 1'b1;
        enable   = 1'b0;
        s_tdata  = 16'hBEEF;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        s_tuser  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_s_tready", 32'(s_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast",  32'(m_tlast),  32'd0);
        check("rst_m_tdata",  32'(m_tdata),  32'd0);
        check("rst_dp_rst",   32'(dp_rst),   32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_pulse",  32'(err_pulse),  32'd0);
        check("rst_frame_cnt",  32'(frame_cnt),  32'd0);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        areset   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Clean frame preceded by junk, no backpressure.
        enable = 1'b1;
        send_junk(10);
        clean_frame_and_check();
        check("lit_fwd_beats", fwd_seen, 32);
        check("lit_tlast_beats", tlast_seen, 4);
        check("lit_frame_cnt1", 32'(frame_cnt), 32'd1);
        check("lit_dp_runs", dp_runs, 1);
        check("lit_done_once", done_seen, 1);

        // Clean frame under random backpressure.
        bp_en = 1;
        clean_frame_and_check();

        // Short line at pixel 3 of line 2, leftovers become junk, then resync.
        send_frame(K_SHORT, 2, 3);
        send_junk(3);
        clean_frame_and_check();
        check("errs_after_short", err_seen, errs_exp);
`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
        check("err_cnt_1", 32'(err_cnt), 32'd1);
`endif

        // Mid-frame SOF at line 2 pixel 0.
        send_frame(K_SOF, 2, 0);
        @(negedge clk);
        check("frame_cnt_after_sof_err", 32'(frame_cnt), frames_exp);
        @(posedge clk);
        #1;
        clean_frame_and_check();

        // Long line on line 1.
        send_frame(K_LONG, 1, 0);
        clean_frame_and_check();
        check("errs_total", err_seen, errs_exp);
        check("lit_errs3", err_seen, 3);
`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
        check("err_cnt_3", 32'(err_cnt), 32'd3);
`endif

        // Enable dropped halfway: frame completes, then idle.
        bp_en = 0;
        send_frame(K_DROP, Y / 2, 0);
        wait_done();
        frames_exp++;
        check("busy_in_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("busy_after_drop", 32'(busy), 32'd0);
        check("frame_cnt_drop", 32'(frame_cnt), frames_exp);
        check("lit_frame_cnt6", 32'(frame_cnt), 32'd6);
        @(posedge clk);
        #1;

        // New run, reset asserted at line 1.
        enable = 1'b1;
        repeat (3) @(negedge clk);
`ifdef BPR_FRAME_CTRL_ERR_CNT_EN
        check("err_cnt_cleared", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        send_frame(K_RST, 1, 0);
        @(negedge clk);
        check("mid_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_rst_dp_rst",   32'(dp_rst),   32'd1);
        check("mid_rst_busy",     32'(busy),     32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (2) @(negedge clk);
        check("mid_rst_no_done", done_seen, frames_exp);
        check("mid_rst_no_err", err_seen, errs_exp);
        check("mid_rst_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;
        enable = 1'b0;
        areset = 1'b0;
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
